// File: rtl/adder4.sv
// adder4: 4-bit carry-lookahead adder with carry-in/carry-out, group
// propagate/generate for cascading, signed-overflow and zero flags, and a
// registered copy of result/cout/ovf for pipelined consumers.
//
// Optional build macro: ADDER4_STICKY_OVF_EN
//   Adds i_ovfClr_1 / o_ovfSticky_1, a sticky flag that is set by any
//   captured overflow or carry-out and cleared by i_ovfClr_1 (set wins).
//   The default build (macro undefined) has neither port nor register.
module adder4 (
    input  logic       i_clk_1,
    input  logic       i_rstn_1,
    input  logic       i_cIn_1,
    input  logic [3:0] i_adderOperand1_4,
    input  logic [3:0] i_adderOperand2_4,
`ifdef ADDER4_STICKY_OVF_EN
    input  logic       i_ovfClr_1,
    output logic       o_ovfSticky_1,
`endif
    output logic [3:0] o_adderResult_4,
    output logic       o_cOut_1,
    output logic       o_groupP_1,
    output logic       o_groupG_1,
    output logic       o_ovf_1,
    output logic       o_zero_1,
    output logic [3:0] o_resultQ_4,
    output logic       o_cOutQ_1,
    output logic       o_ovfQ_1
);

    // Per-bit propagate / generate terms.
    logic [3:0] p;
    logic [3:0] g;

    // Carry into each bit position; c[4] is the carry out of the group.
    logic [4:0] c;

    // Combinational sum and flags.
    logic [3:0] sum;
    logic       grp_p;
    logic       grp_g;
    logic       ovf;
    logic       zero;

    // Registered copies and their next-state values.
    logic [3:0] result_q, result_d;
    logic       cout_q,   cout_d;
    logic       ovf_q,    ovf_d;

`ifdef ADDER4_STICKY_OVF_EN
    logic       sticky_q, sticky_d;
`endif

    // Bitwise propagate and generate.
    always_comb begin
        p = i_adderOperand1_4 ^ i_adderOperand2_4;
        g = i_adderOperand1_4 & i_adderOperand2_4;
    end

    // Lookahead carries, each written as a flat two-level sum of products so
    // no carry depends on a previously computed carry.
    always_comb begin
        c[0] = i_cIn_1;
        c[1] = g[0]
             | (p[0] & i_cIn_1);
        c[2] = g[1]
             | (p[1] & g[0])
             | (p[1] & p[0] & i_cIn_1);
        c[3] = g[2]
             | (p[2] & g[1])
             | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & i_cIn_1);
        c[4] = g[3]
             | (p[3] & g[2])
             | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & i_cIn_1);
    end

    // Group propagate/generate for cascading into a higher-level lookahead unit.
    always_comb begin
        grp_p = p[3] & p[2] & p[1] & p[0];
        grp_g = g[3]
              | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);
    end

    // Sum bits and result flags; overflow is the carry into vs. out of the MSB.
    always_comb begin
        sum  = p ^ c[3:0];
        ovf  = c[4] ^ c[3];
        zero = (sum == 4'h0);
    end

    assign o_adderResult_4 = sum;
    assign o_cOut_1        = c[4];
    assign o_groupP_1      = grp_p;
    assign o_groupG_1      = grp_g;
    assign o_ovf_1         = ovf;
    assign o_zero_1        = zero;

    // Next-state values for the pipeline register: always the live result.
    always_comb begin
        result_d = sum;
        cout_d   = c[4];
        ovf_d    = ovf;
    end

    // Pipeline register; asynchronous reset clears it without a clock.
    always_ff @(posedge i_clk_1 or negedge i_rstn_1) begin
        if (!i_rstn_1) begin
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign o_resultQ_4 = result_q;
    assign o_cOutQ_1   = cout_q;
    assign o_ovfQ_1    = ovf_q;

`ifdef ADDER4_STICKY_OVF_EN
    // Sticky flag next state: a new event takes priority over a clear request.
    always_comb begin
        sticky_d = sticky_q;
        if (ovf || c[4]) begin
            sticky_d = 1'b1;
        end else if (i_ovfClr_1) begin
            sticky_d = 1'b0;
        end
    end

    // Sticky flag register; asynchronous reset.
    always_ff @(posedge i_clk_1 or negedge i_rstn_1) begin
        if (!i_rstn_1) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign o_ovfSticky_1 = sticky_q;
`endif

endmodule

// File: tb/tb_adder4.sv
// Self-checking bench for adder4: hand-written table vectors, random vectors
// against an arithmetic reference model, asynchronous reset checks, and
// (with ADDER4_STICKY_OVF_EN) sticky overflow set/clear sequences.
module tb_adder4;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] res;
        logic       cout;
        logic       ovf;
        logic       zero;
        logic       gp;
        logic       gg;
    } vec_t;

    logic       clk;
    logic       rstn;
    logic       cin;
    logic [3:0] opa;
    logic [3:0] opb;
    logic [3:0] res;
    logic       cout;
    logic       gp;
    logic       gg;
    logic       ovf;
    logic       zero;
    logic [3:0] res_q;
    logic       cout_q;
    logic       ovf_q;
`ifdef ADDER4_STICKY_OVF_EN
    logic       clr;
    logic       sticky;
    logic       sticky_exp;
`endif

    int tests;
    int fails;

    adder4 dut (
        .i_clk_1          (clk),
        .i_rstn_1         (rstn),
        .i_cIn_1          (cin),
        .i_adderOperand1_4(opa),
        .i_adderOperand2_4(opb),
`ifdef ADDER4_STICKY_OVF_EN
        .i_ovfClr_1       (clr),
        .o_ovfSticky_1    (sticky),
`endif
        .o_adderResult_4  (res),
        .o_cOut_1         (cout),
        .o_groupP_1       (gp),
        .o_groupG_1       (gg),
        .o_ovf_1          (ovf),
        .o_zero_1         (zero),
        .o_resultQ_4      (res_q),
        .o_cOutQ_1        (cout_q),
        .o_ovfQ_1         (ovf_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic, signed range test for overflow.
    function automatic vec_t model(input logic [3:0] a, input logic [3:0] b, input logic cin_v);
        vec_t v;
        int   u;
        int   sa;
        int   sb;
        int   s;
        u  = int'(a) + int'(b) + int'(cin_v);
        sa = (a >= 4'd8) ? int'(a) - 16 : int'(a);
        sb = (b >= 4'd8) ? int'(b) - 16 : int'(b);
        s  = sa + sb + int'(cin_v);
        v.a    = a;
        v.b    = b;
        v.cin  = cin_v;
        v.res  = 4'(u % 16);
        v.cout = (u >= 16);
        v.ovf  = (s > 7) || (s < -8);
        v.zero = ((u % 16) == 0);
        v.gp   = ((int'(a) + int'(b)) == 15);
        v.gg   = ((int'(a) + int'(b)) >= 16);
        return v;
    endfunction

    task automatic chk_comb(input string tag, input vec_t e);
        chk({tag, ".res"},  res,        e.res);
        chk({tag, ".cout"}, {3'b0, cout}, {3'b0, e.cout});
        chk({tag, ".ovf"},  {3'b0, ovf},  {3'b0, e.ovf});
        chk({tag, ".zero"}, {3'b0, zero}, {3'b0, e.zero});
        chk({tag, ".gp"},   {3'b0, gp},   {3'b0, e.gp});
        chk({tag, ".gg"},   {3'b0, gg},   {3'b0, e.gg});
    endtask

    task automatic chk_q(input string tag, input logic [3:0] r, input logic co, input logic ov);
        chk({tag, ".resQ"},  res_q,          r);
        chk({tag, ".coutQ"}, {3'b0, cout_q}, {3'b0, co});
        chk({tag, ".ovfQ"},  {3'b0, ovf_q},  {3'b0, ov});
    endtask

    // Drive a vector at the falling edge, check the combinational outputs,
    // then check the pipeline register one rising edge later.
    task automatic step(input string tag, input vec_t e);
        @(negedge clk);
        opa = e.a;
        opb = e.b;
        cin = e.cin;
        #1;
        chk_comb(tag, e);
        @(posedge clk);
`ifdef ADDER4_STICKY_OVF_EN
        if (e.ovf || e.cout) sticky_exp = 1'b1;
        else if (clr)        sticky_exp = 1'b0;
`endif
        #1;
        chk_q(tag, e.res, e.cout, e.ovf);
`ifdef ADDER4_STICKY_OVF_EN
        chk({tag, ".sticky"}, {3'b0, sticky}, {3'b0, sticky_exp});
`endif
    endtask

    vec_t tbl [7];
    vec_t e;
    vec_t held;

    initial begin
        tests = 0;
        fails = 0;
        //           a     b     cin   res   cout  ovf   zero  gp    gg
        tbl[0] = '{4'h3, 4'h4, 1'b0, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{4'h7, 4'h0, 1'b1, 4'h8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{4'h5, 4'hA, 1'b1, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

        rstn = 1'b0;
        cin  = 1'b0;
        opa  = 4'h0;
        opb  = 4'h0;
`ifdef ADDER4_STICKY_OVF_EN
        clr        = 1'b0;
        sticky_exp = 1'b0;
`endif
        #1;
        chk_q("reset", 4'h0, 1'b0, 1'b0);
`ifdef ADDER4_STICKY_OVF_EN
        chk("reset.sticky", {3'b0, sticky}, 4'h0);
`endif
        #1;
        rstn = 1'b1;

        for (int i = 0; i < 7; i++) begin
            step($sformatf("tbl%0d", i), tbl[i]);
        end

        for (int i = 0; i < 100; i++) begin
            e = model(4'($urandom_range(15)), 4'($urandom_range(15)), 1'($urandom_range(1)));
            step($sformatf("rnd%0d", i), e);
        end

        // Asynchronous reset with a nonzero value held in the register.
        held = model(4'h3, 4'h4, 1'b0);
        step("pre_rst", held);
        #2;
        rstn = 1'b0;
        #1;
        chk_q("async_rst", 4'h0, 1'b0, 1'b0);
        chk_comb("rst_comb", held);
`ifdef ADDER4_STICKY_OVF_EN
        sticky_exp = 1'b0;
        chk("async_rst.sticky", {3'b0, sticky}, 4'h0);
`endif
        @(posedge clk);
        #1;
        chk_q("rst_hold", 4'h0, 1'b0, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk_q("rst_release", 4'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk_q("first_capture", held.res, held.cout, held.ovf);

`ifdef ADDER4_STICKY_OVF_EN
        // Overflow event sets the flag, a later clear drops it.
        clr = 1'b0;
        step("stk_set", model(4'h7, 4'h0, 1'b1));
        chk("stk_set.is1", {3'b0, sticky}, 4'h1);
        clr = 1'b1;
        step("stk_clr", model(4'h1, 4'h1, 1'b0));
        chk("stk_clr.is0", {3'b0, sticky}, 4'h0);
        // Event and clear on the same edge: set wins.
        clr = 1'b1;
        step("stk_both", model(4'h7, 4'h0, 1'b1));
        chk("stk_both.is1", {3'b0, sticky}, 4'h1);
        clr = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
